// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request handshake, IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcSrc,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] branchTarget,
    input  logic [25:0] jumpIndex,
    input  logic [31:0] jrAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] reqAddr, reqAddr_d;
    logic [31:0] hold_buf, hold_buf_d;
    logic [31:0] pc_d, instr_d, pc4_d;
    logic        valid_d;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect decode: a stalled or empty ID stage cannot steer the PC
    always_comb begin
        redir    = ifid_valid & ~stall & (pcSrc != 2'd0);
        pc_plus4 = pc + 32'd4;
        case (pcSrc)
            2'd1:    target = branchTarget;
            2'd2:    target = {ifid_pc4[31:28], jumpIndex, 2'b00};
            default: target = jrAddr;
        endcase
    end

    // Next-state and output logic; every IF/ID bubble carries a nop
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        instr_d    = ifid_instr;
        pc4_d      = ifid_pc4;
        valid_d    = ifid_valid;
        reqAddr_d  = reqAddr;
        hold_buf_d = hold_buf;
        imemReq    = 1'b0;
        imemAddr   = pc;
        case (state)
            FETCH: begin
                imemReq = 1'b1;
                if (redir) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    instr_d = 32'd0;
                    if (!imemReady) begin
                        reqAddr_d = pc;
                        state_d   = DISCARD;
                    end
                end else if (imemReady) begin
                    if (stall) begin
                        hold_buf_d = imemData;
                        state_d    = HOLD;
                    end else begin
                        instr_d = flush ? 32'd0 : imemData;
                        pc4_d   = pc_plus4;
                        valid_d = ~flush;
                        pc_d    = pc_plus4;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = 32'd0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (redir) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                        instr_d = 32'd0;
                    end else begin
                        instr_d = flush ? 32'd0 : hold_buf;
                        pc4_d   = pc_plus4;
                        valid_d = ~flush;
                        pc_d    = pc_plus4;
                    end
                end
            end
            DISCARD: begin
                imemReq  = 1'b1;
                imemAddr = reqAddr;
                if (imemReady) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (rst) begin
            imemReq = 1'b0;
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            reqAddr    <= 32'd0;
            hold_buf   <= 32'd0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            ifid_instr <= instr_d;
            ifid_pc4   <= pc4_d;
            ifid_valid <= valid_d;
            reqAddr    <= reqAddr_d;
            hold_buf   <= hold_buf_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based model
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  pcSrc;
    logic        flush;
    logic        stall;
    logic [31:0] branchTarget;
    logic [25:0] jumpIndex;
    logic [31:0] jrAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int n_cmp = 0;
    int n_err = 0;

    // model: architectural view plus queues for a buffered word and a request to drop
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] held[$];
    logic [31:0] drop[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pcSrc(pcSrc), .flush(flush), .stall(stall),
        .branchTarget(branchTarget), .jumpIndex(jumpIndex), .jrAddr(jrAddr),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory returns 0x2000_0000 + address when ready
    assign imemData = imemReady ? (32'h2000_0000 + imemAddr) : 32'h0BAD_F00D;

    task automatic drive(input logic r, input logic [1:0] s, input logic f, input logic st, input logic rdy);
        rst = r; pcSrc = s; flush = f; stall = st; imemReady = rdy;
    endtask

    task automatic issue(input logic [31:0] w);
        m_instr = flush ? 32'd0 : w;
        m_pc4   = m_pc + 32'd4;
        m_valid = !flush;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic bubble();
        m_valid = 1'b0;
        m_instr = 32'd0;
    endtask

    // advance model by one edge with the current inputs, then clock the DUT
    task automatic tick();
        logic [31:0] tgt;
        logic        rd;
        rd = m_valid && !stall && (pcSrc != 2'd0);
        case (pcSrc)
            2'd1:    tgt = branchTarget;
            2'd2:    tgt = {m_pc4[31:28], jumpIndex, 2'b00};
            default: tgt = jrAddr;
        endcase
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            held.delete(); drop.delete();
        end else if (drop.size() > 0) begin
            if (imemReady) drop.delete();
        end else if (held.size() > 0) begin
            if (!stall) begin
                if (rd) begin
                    m_pc = tgt; bubble(); held.delete();
                end else begin
                    issue(held.pop_front());
                end
            end
        end else begin
            if (rd) begin
                if (!imemReady) drop.push_back(m_pc);
                m_pc = tgt; bubble();
            end else if (imemReady) begin
                if (stall) held.push_back(32'h2000_0000 + m_pc);
                else issue(32'h2000_0000 + m_pc);
            end else if (!stall) begin
                bubble();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imemReq); end
        tick(); tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
            n_err++; $display("FAIL reset_ifid: got %b %h %h want 0 0 0", ifid_valid, ifid_instr, ifid_pc4); end
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
            #1;
            n_cmp++; if (imemAddr !== 32'(4*(k-1))) begin n_err++; $display("FAIL seq_addr: got %h want %h", imemAddr, 4*(k-1)); end
            tick();
            n_cmp++; if (pc !== 32'(4*k)) begin n_err++; $display("FAIL seq_pc: got %h want %h", pc, 4*k); end
            n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'(4*k) || ifid_instr !== 32'h2000_0000 + 32'(4*(k-1))) begin
                n_err++; $display("FAIL seq_ifid: got %b %h %h want 1 %h %h", ifid_valid, ifid_pc4, ifid_instr, 4*k, 32'h2000_0000 + 32'(4*(k-1))); end
        end
    endtask

    task automatic test_branch();
        run_seq(2);
        branchTarget = 32'h40;
        drive(1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemAddr !== 32'h40) begin n_err++; $display("FAIL br_addr: got %h want 40", imemAddr); end
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL br_bubble: got %b want 0", ifid_valid); end
        tick();
        n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h44) begin
            n_err++; $display("FAIL br_land: got %b %h want 1 44", ifid_valid, ifid_pc4); end
    endtask

    task automatic test_jump();
        run_seq(2);
        branchTarget = 32'h1000_0004;
        drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (ifid_pc4 !== 32'h1000_0008) begin n_err++; $display("FAIL j_pc4: got %h want 10000008", ifid_pc4); end
        jumpIndex = 26'h10;
        drive(1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemAddr !== 32'h1000_0040) begin n_err++; $display("FAIL j_addr: got %h want 10000040", imemAddr); end
        tick();
        jrAddr = 32'h80;
        drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemAddr !== 32'h80) begin n_err++; $display("FAIL jr_addr: got %h want 80", imemAddr); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] p0, i0, c0;
        run_seq(2);
        p0 = m_pc; i0 = m_instr; c0 = m_pc4;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
            tick();
            n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL st_req: got %b want 0", imemReq); end
            n_cmp++; if (pc !== p0 || ifid_instr !== i0 || ifid_pc4 !== c0) begin
                n_err++; $display("FAIL st_hold: got %h %h %h want %h %h %h", pc, ifid_instr, ifid_pc4, p0, i0, c0); end
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL st_norefetch: got %b want 0", imemReq); end
        tick();
        n_cmp++; if (ifid_instr !== 32'h2000_0000 + p0 || pc !== p0 + 32'd4 || ifid_pc4 !== p0 + 32'd4 || ifid_valid !== 1'b1) begin
            n_err++; $display("FAIL st_release: got %h %h %h %b want %h %h %h 1", ifid_instr, pc, ifid_pc4, ifid_valid,
                32'h2000_0000 + p0, p0 + 32'd4, p0 + 32'd4); end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] p0;
        run_seq(2);
        p0 = m_pc;
        branchTarget = 32'h200;
        drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            #1;
            n_cmp++; if (imemReq !== 1'b1 || imemAddr !== p0) begin
                n_err++; $display("FAIL rw_addr: got %b %h want 1 %h", imemReq, imemAddr, p0); end
            tick();
            n_cmp++; if (ifid_valid !== 1'b0 || pc !== 32'h200) begin
                n_err++; $display("FAIL rw_wait: got %b %h want 0 200", ifid_valid, pc); end
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemAddr !== p0) begin n_err++; $display("FAIL rw_done_addr: got %h want %h", imemAddr, p0); end
        tick();
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop: got %b want 0", ifid_valid); end
        #1;
        n_cmp++; if (imemAddr !== 32'h200) begin n_err++; $display("FAIL rw_tgt_addr: got %h want 200", imemAddr); end
        tick();
        n_cmp++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2000_0200 || ifid_pc4 !== 32'h204) begin
            n_err++; $display("FAIL rw_land: got %b %h %h want 1 20000200 204", ifid_valid, ifid_instr, ifid_pc4); end
    endtask

    task automatic test_reset_discard();
        run_seq(2);
        branchTarget = 32'h300;
        drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL rd_req: got %b want 0", imemReq); end
        tick();
        n_cmp++; if (pc !== 32'h0 || ifid_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_state: got %h %b want 0 0", pc, ifid_valid); end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (ifid_valid !== 1'b1 || pc !== 32'h4) begin
            n_err++; $display("FAIL rd_fetch: got %b %h want 1 4", ifid_valid, pc); end
    endtask

    task automatic test_wrap();
        run_seq(2);
        branchTarget = 32'hFFFF_FFFC;
        drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (imemAddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", imemAddr); end
        tick();
        n_cmp++; if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc: got %h %h %b want 0 0 1", pc, ifid_pc4, ifid_valid); end
    endtask

    task automatic test_random();
        logic        e_req;
        logic [31:0] e_addr;
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3)),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 7));
            branchTarget = $urandom();
            jumpIndex    = 26'($urandom());
            jrAddr       = $urandom();
            #1;
            e_req  = !rst && (held.size() == 0);
            e_addr = (drop.size() > 0) ? drop[0] : m_pc;
            n_cmp++; if (imemReq !== e_req) begin n_err++; $display("FAIL rnd_req @%0d: got %b want %b", i, imemReq, e_req); end
            if (e_req) begin
                n_cmp++; if (imemAddr !== e_addr) begin n_err++; $display("FAIL rnd_addr @%0d: got %h want %h", i, imemAddr, e_addr); end
            end
            tick();
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc @%0d: got %h want %h", i, pc, m_pc); end
            n_cmp++; if (ifid_valid !== m_valid || ifid_instr !== m_instr) begin
                n_err++; $display("FAIL rnd_ifid @%0d: got %b %h want %b %h", i, ifid_valid, ifid_instr, m_valid, m_instr); end
            if (m_valid) begin
                n_cmp++; if (ifid_pc4 !== m_pc4) begin n_err++; $display("FAIL rnd_pc4 @%0d: got %h want %h", i, ifid_pc4, m_pc4); end
            end
        end
    endtask

    initial begin
        branchTarget = 32'h0;
        jumpIndex    = 26'h0;
        jrAddr       = 32'h0;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_redirect_wait();
        test_reset_discard();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
